gray_pos_decoder: RTL and testbench

Receives a free-running Gray-coded position word, for example from an absolute encoder or a Gray counter in another block, and turns it into step events. It synchronizes the word, converts it to binary and classifies each change as forward, backward, none or illegal. It keeps a signed-agnostic wrapping position accumulator. It is the receiving end of the bin_to_gray path: it consumes Gray codes and produces binary position and motion events.

---
 rtl/gray_pos_decoder_pkg.sv | 7 +
 rtl/gray_pos_decoder_gray_to_bin.sv | 12 +
 rtl/gray_pos_decoder.sv | 106 ++++++++++
 tb/tb_gray_pos_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pos_decoder_pkg.sv
// Shared types and constants for the Gray position decoder.
package gray_pos_decoder_pkg;
  typedef enum logic {PRIME = 1'b0, TRACK = 1'b1} state_e;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam int   ERR_CNT_W = 8;
endpackage

// File: rtl/gray_pos_decoder_gray_to_bin.sv
// Combinational Gray-to-binary conversion: each binary bit is the XOR of all
// Gray bits at and above it.
module gray_to_bin #(
  parameter int BIT = 8
) (
  input  logic [BIT-1:0] i_gray,
  output logic [BIT-1:0] o_bin
);
  for (genvar i = 0; i < BIT; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[BIT-1:i];
  end
endmodule

// File: rtl/gray_pos_decoder.sv
// Synchronizes a Gray position word, converts to binary and turns each change
// into step/error events. Optional saturating error counter: GRAY_DEC_ERR_CNT_EN.
module gray_pos_decoder
  import gray_pos_decoder_pkg::*;
#(
  parameter int BIT         = 8,
  parameter int POSW        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [BIT-1:0]       i_gray,
  input  logic                 i_en,
  input  logic                 i_clr,
  output logic [BIT-1:0]       o_bin,
  output logic [POSW-1:0]      o_pos,
  output logic                 o_step,
  output logic                 o_dir,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);
  logic [SYNC_STAGES-1:0][BIT-1:0] r_sync;
  logic [BIT-1:0]  r_bin;
  logic [POSW-1:0] r_pos;
  logic            r_step, r_dir, r_err;
  state_e          r_state;

  logic [BIT-1:0]  w_bcur, w_delta;
  state_e          w_nstate;
  logic            w_step, w_err, w_up;

  gray_to_bin #(.BIT(BIT)) u_g2b (
    .i_gray (r_sync[SYNC_STAGES-1]),
    .o_bin  (w_bcur)
  );

  assign w_delta = w_bcur - r_bin;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= PRIME;
    else       r_state <= w_nstate;
  end

  // PRIME swallows the first sample so the post-reset load is never an event
  always_comb begin
    w_nstate = r_state;
    w_step   = 1'b0;
    w_err    = 1'b0;
    w_up     = r_dir;
    case (r_state)
      PRIME: w_nstate = TRACK;
      TRACK: begin
        if (w_delta == BIT'(1)) begin
          w_step = 1'b1;
          w_up   = DIR_UP;
        end else if (w_delta == {BIT{1'b1}}) begin
          w_step = 1'b1;
          w_up   = DIR_DN;
        end else if (w_delta != '0) begin
          w_err  = 1'b1;
        end
      end
      default: w_nstate = PRIME;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_bin  <= '0;
      r_pos  <= '0;
      r_step <= 1'b0;
      r_dir  <= DIR_UP;
      r_err  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_gray};
      r_bin  <= w_bcur;
      r_step <= w_step;
      r_err  <= w_err;
      if (w_step) r_dir <= w_up;
      if (i_clr)
        r_pos <= '0;
      else if (w_step && i_en)
        r_pos <= w_up ? r_pos + POSW'(1) : r_pos - POSW'(1);
    end
  end

`ifdef GRAY_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      r_err_cnt <= '0;
    else if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}}))
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
  end
  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = '0;
`endif

  assign o_bin  = r_bin;
  assign o_pos  = r_pos;
  assign o_step = r_step;
  assign o_dir  = r_dir;
  assign o_err  = r_err;
endmodule

// File: tb/tb_gray_pos_decoder.sv
// Randomized scoreboard bench for gray_pos_decoder (BIT=8, POSW=16, SYNC_STAGES=2).
module tb_gray_pos_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  gray = 8'd0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic [7:0]  o_bin;
  logic [15:0] o_pos;
  logic        o_step, o_dir, o_err;
  logic [7:0]  o_err_cnt;

  gray_pos_decoder #(.BIT(8), .POSW(16), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_gray(gray), .i_en(en), .i_clr(clr),
    .o_bin(o_bin), .o_pos(o_pos), .o_step(o_step), .o_dir(o_dir),
    .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_steps = 0, n_errs = 0;
  bit started = 0;

  // reference model state
  logic [7:0]  m_pipe[$];
  bit          m_prime;
  logic [7:0]  m_bin;
  logic [15:0] m_pos;
  logic        m_dir;
  logic [7:0]  m_ecnt;
  logic [26:0] exp_q[$];

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] to_gray(int v);
    int b = v % 256;
    return 8'(b ^ (b / 2));
  endfunction

  function automatic logic [7:0] from_gray(logic [7:0] g);
    int b = g;
    int s = g / 2;
    while (s != 0) begin
      b = b ^ s;
      s = s / 2;
    end
    return 8'(b);
  endfunction

  // Model: two-deep delay of raw Gray samples, then classify the binary delta
  task automatic model_step();
    logic [7:0] cur, d;
    bit st, er, up;
    if (rst) begin
      m_pipe = {8'd0, 8'd0};
      m_prime = 1; m_bin = 0; m_pos = 0; m_dir = 1; m_ecnt = 0;
      started = 1;
      return;
    end
    if (!started) return;
    cur = from_gray(m_pipe[1]);
    void'(m_pipe.pop_back());
    m_pipe.push_front(gray);
    st = 0; er = 0; up = m_dir;
    if (m_prime) m_prime = 0;
    else begin
      d = cur - m_bin;
      if (d == 8'd1) begin st = 1; up = 1; end
      else if (d == 8'd255) begin st = 1; up = 0; end
      else if (d != 8'd0) er = 1;
    end
    m_bin = cur;
    if (st) m_dir = up;
    if (clr) m_pos = 0;
    else if (st && en) m_pos = up ? m_pos + 16'd1 : m_pos - 16'd1;
`ifdef GRAY_DEC_ERR_CNT_EN
    if (clr) m_ecnt = 0;
    else if (er && m_ecnt < 8'd255) m_ecnt = m_ecnt + 8'd1;
`endif
    if (st || er) exp_q.push_back({st, er, m_dir, m_pos, m_bin});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: pops one expectation per DUT event, and tracks visible state
  initial forever begin
    logic [26:0] e;
    @(negedge clk);
    if (started) begin
      chk("state", {o_pos, o_bin, o_dir, o_err_cnt}, {m_pos, m_bin, m_dir, m_ecnt});
      if (o_step || o_err) begin
        if (o_step) n_steps++;
        if (o_err)  n_errs++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL event: got step=%0b err=%0b expected no event at %0t", o_step, o_err, $time);
        end else begin
          e = exp_q.pop_front();
          chk("event", {o_step, o_err, o_dir, o_pos, o_bin}, e);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_chk++;
        $display("FAIL event: got no event expected 0x%0h at %0t", e, $time);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(int v);
    gray = to_gray(v);
  endtask

  task automatic do_reset();
    rst = 1; tick(2); rst = 0;
  endtask

  task automatic clr_cnt();
    n_steps = 0; n_errs = 0;
  endtask

  initial begin
    int v;
    // idle after reset
    put(0); do_reset(); clr_cnt(); tick(5);
    chk("idle_pos", o_pos, 0);
    chk("idle_steps", n_steps, 0);
    chk("idle_dir", o_dir, 1);
    chk("idle_errs", n_errs, 0);

    // count up 0..9
    for (int i = 1; i <= 9; i++) begin put(i); tick(4); end
    chk("up_steps", n_steps, 9);
    chk("up_pos", o_pos, 9);
    chk("up_dir", o_dir, 1);
    chk("up_bin", o_bin, 9);

    // down through the wrap
    put(0); do_reset(); clr_cnt(); tick(3);
    put(255); tick(4); put(254); tick(4);
    chk("wrap_steps", n_steps, 2);
    chk("wrap_errs", n_errs, 0);
    chk("wrap_pos", o_pos, 16'hFFFE);
    chk("wrap_dir", o_dir, 0);

    // illegal jump then recovery
    put(0); do_reset(); tick(3);
    for (int i = 1; i <= 5; i++) begin put(i); tick(4); end
    clr_cnt(); put(9); tick(4);
    chk("jump_errs", n_errs, 1);
    chk("jump_pos", o_pos, 5);
    chk("jump_bin", o_bin, 9);
    put(10); tick(4);
    chk("recover_steps", n_steps, 1);
    chk("recover_pos", o_pos, 6);

    // enable low, then clear racing a step
    en = 0; clr_cnt();
    for (int i = 11; i <= 13; i++) begin put(i); tick(4); end
    chk("hold_steps", n_steps, 3);
    chk("hold_pos", o_pos, 6);
    en = 1; put(14); clr = 1; tick(4); clr = 0;
    chk("clr_steps", n_steps, 4);
    chk("clr_pos", o_pos, 0);

    // randomized walk with occasional jumps, clears, enables and resets
    v = 14;
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 45) v = (v + 1) % 256;
      else if (r < 90) v = (v + 255) % 256;
      else if (r < 97) v = $urandom_range(0, 255);
      put(v);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      if (r >= 98) begin rst = 1; tick(1); rst = 0; end
      tick($urandom_range(1, 3));
    end
    clr = 0; en = 1; tick(4);

    // error counter saturation
    put(0); do_reset(); tick(3); clr_cnt();
    for (int i = 0; i < 260; i++) begin put((i % 2 == 0) ? 128 : 0); tick(2); end
    tick(4);
    chk("sat_errs", n_errs, 260);
`ifdef GRAY_DEC_ERR_CNT_EN
    chk("sat_cnt", o_err_cnt, 255);
`else
    chk("sat_cnt", o_err_cnt, 0);
`endif
    put(128); tick(1); do_reset(); put(0); clr_cnt();
    chk("rst_cnt", o_err_cnt, 0);
    chk("rst_pos", o_pos, 0);
    tick(6);
    chk("rst_no_steps", n_steps, 0);
    chk("rst_no_errs", n_errs, 0);

    tick(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
